// File: rtl/pe_block_gen.sv
// Variable-node processing element: intrinsic store, three-stage VNU
// pipeline, hard-decision RAM with flip counting.
module pe_block_gen #(
  parameter int J             = 3,
  parameter int ADDR_WIDTH    = 5,
  parameter int MESSAGE_WIDTH = 5
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  load_valid,
  input  logic [ADDR_WIDTH-1:0]                 load_add_in,
  input  logic [MESSAGE_WIDTH-1:0]              int_in,
  output logic [ADDR_WIDTH-1:0]                 load_add_out,
  output logic [MESSAGE_WIDTH-1:0]              int_out,
  output logic                                  load_valid_out,
  input  logic                                  vnu_valid,
  input  logic [ADDR_WIDTH-1:0]                 vnu_add,
  input  logic [J-1:0][MESSAGE_WIDTH-1:0]       cnu_data_in,
  output logic [J-1:0][MESSAGE_WIDTH:0]         cnu_data_out,
  output logic                                  enable_cnu,
  input  logic [ADDR_WIDTH-1:0]                 read_add_in,
  output logic                                  dec_out,
  output logic [ADDR_WIDTH:0]                   flips,
  input  logic                                  iter_clr,
  output logic                                  load_err
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam int MW        = MESSAGE_WIDTH;
  localparam int TW        = MW + 4;

  localparam logic signed [TW-1:0] SMAX = TW'((1 << MW) - 1);
  localparam logic signed [TW-1:0] SMIN = -SMAX;
  localparam logic [ADDR_WIDTH:0]  FMAX = (ADDR_WIDTH+1)'(RAM_DEPTH);

  // Negative zero maps to 0 naturally: ~0 + 1 wraps to 0.
  function automatic logic [MW-1:0] to_tc(input logic [MW-1:0] x);
    logic [MW-1:0] m;
    m = {1'b0, x[MW-2:0]};
    return x[MW-1] ? (~m + 1'b1) : m;
  endfunction

  function automatic logic signed [TW-1:0] ext(input logic [MW-1:0] x);
    return TW'($signed(x));
  endfunction

  logic [MW-1:0]         intr_mem [RAM_DEPTH];
  logic [RAM_DEPTH-1:0]  dec_mem;

  logic                  v0, v1, v2;
  logic [ADDR_WIDTH-1:0] a0, a1, a2;
  logic [J-1:0][MW-1:0]  d0, conv, c1, c2;
  logic [MW-1:0]         i1;
  logic signed [TW-1:0]  total, t2;
  logic [J-1:0][MW:0]    out_c;
  logic                  busy, wr_ok, new_dec, changed;

  assign busy    = v0 | v1 | v2 | enable_cnu;
  assign wr_ok   = load_valid & ~busy;
  assign new_dec = t2[TW-1];
  assign changed = v2 & (dec_mem[a2] != new_dec);

  always_comb begin
    conv = '0;
    for (int j = 0; j < J; j++) conv[j] = to_tc(d0[j]);
  end

  always_comb begin
    total = ext(i1);
    for (int j = 0; j < J; j++) total = total + ext(c1[j]);
  end

  // Symmetric clamp keeps -2^MW off the output bus.
  always_comb begin
    logic signed [TW-1:0] diff;
    out_c = '0;
    diff  = '0;
    for (int j = 0; j < J; j++) begin
      diff = t2 - ext(c2[j]);
      if (diff > SMAX)      out_c[j] = (MW+1)'(SMAX);
      else if (diff < SMIN) out_c[j] = (MW+1)'(SMIN);
      else                  out_c[j] = (MW+1)'(diff);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) intr_mem[load_add_in] <= int_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_add_out   <= '0;
      int_out        <= '0;
      load_valid_out <= 1'b0;
      v0             <= 1'b0;
      v1             <= 1'b0;
      v2             <= 1'b0;
      a0             <= '0;
      a1             <= '0;
      a2             <= '0;
      d0             <= '0;
      c1             <= '0;
      c2             <= '0;
      i1             <= '0;
      t2             <= '0;
      enable_cnu     <= 1'b0;
      cnu_data_out   <= '0;
      dec_mem        <= '0;
      dec_out        <= 1'b0;
      flips          <= '0;
      load_err       <= 1'b0;
    end else begin
      load_add_out   <= load_add_in;
      int_out        <= int_in;
      load_valid_out <= load_valid;
      v0             <= vnu_valid;
      a0             <= vnu_add;
      d0             <= cnu_data_in;
      v1             <= v0;
      a1             <= a0;
      i1             <= to_tc(intr_mem[a0]);
      c1             <= conv;
      v2             <= v1;
      a2             <= a1;
      t2             <= total;
      c2             <= c1;
      enable_cnu     <= v2;
      cnu_data_out   <= v2 ? out_c : '0;
      if (v2) dec_mem[a2] <= new_dec;
      dec_out <= (v2 && a2 == read_add_in) ? new_dec
                                           : dec_mem[read_add_in];
      if (iter_clr)
        flips <= '0;
      else if (changed && flips != FMAX)
        flips <= flips + 1'b1;
      if (load_valid && busy) load_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pe_block_gen.sv
// Bench for pe_block_gen: queue-based behavioural model plus
// directed vectors with hand-computed expectations.
module tb_pe_block_gen;

  localparam int J  = 3;
  localparam int AW = 5;
  localparam int MW = 5;
  localparam int D  = 1 << AW;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 load_valid = 1'b0;
  logic [AW-1:0]        load_add_in = '0;
  logic [MW-1:0]        int_in = '0;
  logic [AW-1:0]        load_add_out;
  logic [MW-1:0]        int_out;
  logic                 load_valid_out;
  logic                 vnu_valid = 1'b0;
  logic [AW-1:0]        vnu_add = '0;
  logic [J-1:0][MW-1:0] cnu_data_in = '0;
  logic [J-1:0][MW:0]   cnu_data_out;
  logic                 enable_cnu;
  logic [AW-1:0]        read_add_in = '0;
  logic                 dec_out;
  logic [AW:0]          flips;
  logic                 iter_clr = 1'b0;
  logic                 load_err;

  always #5 clk = ~clk;

  pe_block_gen #(.J(J), .ADDR_WIDTH(AW), .MESSAGE_WIDTH(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_add_in(load_add_in),
    .int_in(int_in), .load_add_out(load_add_out),
    .int_out(int_out), .load_valid_out(load_valid_out),
    .vnu_valid(vnu_valid), .vnu_add(vnu_add),
    .cnu_data_in(cnu_data_in), .cnu_data_out(cnu_data_out),
    .enable_cnu(enable_cnu), .read_add_in(read_add_in),
    .dec_out(dec_out), .flips(flips),
    .iter_clr(iter_clr), .load_err(load_err)
  );

  int n_chk = 0;
  int n_err = 0;
  int en_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int sm(input logic [MW-1:0] x);
    int m;
    m = int'(x[MW-2:0]);
    return x[MW-1] ? -m : m;
  endfunction

  function automatic logic [MW:0] sat(input int v);
    int lim;
    lim = (1 << MW) - 1;
    if (v > lim) v = lim;
    if (v < -lim) v = -lim;
    return (MW+1)'(v);
  endfunction

  typedef struct packed {
    logic [31:0]          due;
    logic [AW-1:0]        addr;
    logic                 dec;
    logic [J-1:0][MW:0]   out;
  } ent_t;

  ent_t               q[$];
  int                 intr_m [D];
  bit                 dec_m [D];
  int                 flips_m = 0;
  int                 cyc = 0;
  logic               exp_en = 1'b0;
  logic               exp_dec = 1'b0;
  logic               exp_err = 1'b0;
  logic               exp_lvo = 1'b0;
  logic [AW-1:0]      exp_la = '0;
  logic [MW-1:0]      exp_io = '0;
  logic [J-1:0][MW:0] exp_out = '0;

  // Model: what each output must hold after every edge.
  always @(posedge clk or negedge rst_n) begin : model
    bit   busy;
    ent_t e;
    int   tot;
    if (!rst_n) begin
      q.delete();
      foreach (dec_m[i]) dec_m[i] = 1'b0;
      flips_m = 0;
      exp_en  = 1'b0;
      exp_out = '0;
      exp_dec = 1'b0;
      exp_err = 1'b0;
      exp_la  = '0;
      exp_io  = '0;
      exp_lvo = 1'b0;
    end else begin
      cyc++;
      busy = (q.size() > 0) || exp_en;
      exp_en = 1'b0;
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        if (dec_m[e.addr] != e.dec && flips_m < D) flips_m++;
        dec_m[e.addr] = e.dec;
        exp_en  = 1'b1;
        exp_out = e.out;
      end
      if (iter_clr) flips_m = 0;
      exp_la  = load_add_in;
      exp_io  = int_in;
      exp_lvo = load_valid;
      if (load_valid) begin
        if (busy) exp_err = 1'b1;
        else intr_m[load_add_in] = sm(int_in);
      end
      if (vnu_valid) begin
        tot = intr_m[vnu_add];
        for (int j = 0; j < J; j++) tot += sm(cnu_data_in[j]);
        e.due  = cyc + 3;
        e.addr = vnu_add;
        e.dec  = (tot < 0);
        for (int j = 0; j < J; j++)
          e.out[j] = sat(tot - sm(cnu_data_in[j]));
        q.push_back(e);
      end
      exp_dec = dec_m[read_add_in];
    end
  end

  always @(negedge clk) begin
    chk("enable_cnu", 32'(enable_cnu), 32'(exp_en));
    if (exp_en)
      for (int j = 0; j < J; j++)
        chk("cnu_data_out", 32'(cnu_data_out[j]), 32'(exp_out[j]));
    chk("dec_out", 32'(dec_out), 32'(exp_dec));
    chk("flips", 32'(flips), 32'(flips_m));
    chk("load_err", 32'(load_err), 32'(exp_err));
    chk("load_add_out", 32'(load_add_out), 32'(exp_la));
    chk("int_out", 32'(int_out), 32'(exp_io));
    chk("load_valid_out", 32'(load_valid_out), 32'(exp_lvo));
    if (enable_cnu) en_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [MW-1:0] v);
    load_valid  = 1'b1;
    load_add_in = AW'(a);
    int_in      = v;
    tick();
    load_valid  = 1'b0;
  endtask

  task automatic vnu(input int a, input logic [MW-1:0] x0,
                     input logic [MW-1:0] x1, input logic [MW-1:0] x2);
    vnu_valid      = 1'b1;
    vnu_add        = AW'(a);
    cnu_data_in[0] = x0;
    cnu_data_in[1] = x1;
    cnu_data_in[2] = x2;
    tick();
    vnu_valid      = 1'b0;
  endtask

  // Returns edges after the sampling edge until enable_cnu.
  task automatic wait_en(output int lat);
    int k;
    for (k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (enable_cnu) break;
    end
    lat = k - 1;
    if (k > 12) chk("en_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int lat;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_enable", 32'(enable_cnu), 32'd0);
    chk("rst_flips", 32'(flips), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    chk("rst_cnu_out", 32'(cnu_data_out), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    load(4, 5'h05);
    load(7, 5'h1F);
    load(9, 5'h10);

    vnu(4, 5'h03, 5'h12, 5'h07);
    wait_en(lat);
    chk("latency", 32'(lat), 32'd3);
    chk("basic_out0", 32'(cnu_data_out[0]), 32'd10);
    chk("basic_out1", 32'(cnu_data_out[1]), 32'd15);
    chk("basic_out2", 32'(cnu_data_out[2]), 32'd6);
    chk("basic_flips", 32'(flips), 32'd0);

    vnu(7, 5'h1F, 5'h1F, 5'h1F);
    wait_en(lat);
    chk("sat_out0", 32'(cnu_data_out[0]), 32'h21);
    chk("sat_out2", 32'(cnu_data_out[2]), 32'h21);
    chk("sat_flips", 32'(flips), 32'd1);
    read_add_in = 5'd7;
    @(negedge clk);
    chk("sat_dec", 32'(dec_out), 32'd1);

    vnu(9, 5'h10, 5'h10, 5'h10);
    wait_en(lat);
    chk("negz_out", 32'(cnu_data_out), 32'd0);
    read_add_in = 5'd9;
    @(negedge clk);
    chk("negz_dec", 32'(dec_out), 32'd0);

    repeat (2) tick();
    for (int i = 0; i < D; i++) load(i, MW'((i * 7) % 32));
    en_cnt = 0;
    read_add_in = 5'd31;
    vnu_valid = 1'b1;
    for (int i = 0; i < D; i++) begin
      vnu_add        = AW'(i);
      cnu_data_in[0] = MW'((i * 3) % 32);
      cnu_data_in[1] = MW'((i * 5 + 1) % 32);
      cnu_data_in[2] = MW'((i * 11 + 2) % 32);
      tick();
    end
    vnu_valid = 1'b0;
    repeat (6) tick();
    chk("stream_en_cycles", 32'(en_cnt), 32'd32);
    chk("stream_dec31", 32'(dec_out), 32'd1);

    iter_clr = 1'b1;
    tick();
    iter_clr = 1'b0;
    vnu(4, 5'h00, 5'h00, 5'h00);
    load(4, 5'h0A);
    wait_en(lat);
    chk("haz_out0", 32'(cnu_data_out[0]), 32'h34);
    chk("haz_load_err", 32'(load_err), 32'd1);
    chk("haz_flips", 32'(flips), 32'd1);

    repeat (2) tick();
    load(4, 5'h05);
    vnu(4, 5'h00, 5'h00, 5'h00);
    repeat (2) tick();
    iter_clr = 1'b1;
    tick();
    iter_clr = 1'b0;
    @(negedge clk);
    chk("clr_enable", 32'(enable_cnu), 32'd1);
    chk("clr_out0", 32'(cnu_data_out[0]), 32'd5);
    chk("clr_flips", 32'(flips), 32'd0);

    repeat (3) tick();
    vnu_valid = 1'b1;
    vnu_add = 5'd4;
    tick();
    vnu_add = 5'd5;
    tick();
    vnu_valid = 1'b0;
    rst_n = 1'b0;
    en_cnt = 0;
    tick();
    rst_n = 1'b1;
    repeat (8) tick();
    chk("rst_no_enable", 32'(en_cnt), 32'd0);
    for (int i = 0; i < D; i++) begin
      read_add_in = AW'(i);
      @(posedge clk);
      @(negedge clk);
      chk("rst_dec_clear", 32'(dec_out), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
